// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and widths for the pipeline sequencing controller
package pipe_ctrl_pkg;

    localparam int ST_W   = 2;
    localparam int REG_AW = 5;

    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_ERROR    = 2'd2;

    // Encoding 3 is never entered; bit 1 set means "treat as ERROR".
    function automatic logic is_error_state(input logic [ST_W-1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/loaduse_detect.sv
// rtl/loaduse_detect.sv - combinational load-use hazard compare between ID and EX
module loaduse_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memtoreg_i,
    input  logic [REG_AW-1:0] ex_wherereg_i,
    output logic              lu
);

    logic dest_nonzero;
    logic rs_match;
    logic rt_match;

    // A load into register 0 never produces a value, so it cannot cause a hazard.
    assign dest_nonzero = (ex_wherereg_i != '0);
    assign rs_match     = (ex_wherereg_i == id_rs_i);
    assign rt_match     = id_uses_rt_i && (ex_wherereg_i == id_rt_i);

    assign lu = ex_memtoreg_i && dest_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - PC / pipeline-register enable and flush sequencing with memory-wait timeout
module pipe_stall_ctrl #(
    parameter int REG_AW  = pipe_ctrl_pkg::REG_AW,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [REG_AW-1:0] ID_RS,
    input  logic [REG_AW-1:0] ID_RT,
    input  logic              ID_USES_RT,
    input  logic              EX_MEMTOREG,
    input  logic [REG_AW-1:0] EX_WHEREREG,
    input  logic              BRANCH_TAKEN,
    input  logic              MEM_REQ,
    input  logic              MEM_READY,
    output logic              PC_EN,
    output logic              IFID_EN,
    output logic              IFID_FLUSH,
    output logic              IDEX_EN,
    output logic              IDEX_FLUSH,
    output logic              EXMEM_EN,
    output logic              MEMWB_EN,
    output logic              MEMWB_FLUSH,
    output logic              MEM_ERR,
    output logic [1:0]        STATE,
    output logic [CNT_W-1:0]  STALL_CYCLES
);
    import pipe_ctrl_pkg::*;

    localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              lu;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, memwb_flush;

    loaduse_detect #(
        .REG_AW (REG_AW)
    ) u_loaduse_detect (
        .id_rs_i       (ID_RS),
        .id_rt_i       (ID_RT),
        .id_uses_rt_i  (ID_USES_RT),
        .ex_memtoreg_i (EX_MEMTOREG),
        .ex_wherereg_i (EX_WHEREREG),
        .lu            (lu)
    );

    // Mealy control: enables/flushes act in the same cycle as the hazard is seen.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_err_d   = mem_err_q;

        if (RESET) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            state_d     = ST_RUN;
            wcnt_d      = '0;
            mem_err_d   = 1'b0;
        end else if (is_error_state(state_q)) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
        end else if ((state_q == ST_RUN && MEM_REQ && !MEM_READY) ||
                     (state_q == ST_MEM_WAIT && !MEM_READY)) begin
            // Freeze everything up to MEM and push a bubble into WB.
            // A branch in the frozen EX stage is re-presented on release.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
                wcnt_d  = WCNT_W'(1);
            end else if (wcnt_q == WCNT_LAST) begin
                state_d   = ST_ERROR;
                mem_err_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else begin
            // Memory satisfied (or idle): branch squash beats load-use bubble.
            if (BRANCH_TAKEN) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            state_d = ST_RUN;
            wcnt_d  = '0;
        end
    end

    // Saturating performance count of stalled-PC cycles outside reset and ERROR.
    always_comb begin
        stall_d = stall_q;
        if (RESET) begin
            stall_d = '0;
        end else if (!is_error_state(state_q) && !pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Registered controller state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
        end
    end

    assign PC_EN        = pc_en;
    assign IFID_EN      = ifid_en;
    assign IFID_FLUSH   = ifid_flush;
    assign IDEX_EN      = idex_en;
    assign IDEX_FLUSH   = idex_flush;
    assign EXMEM_EN     = exmem_en;
    assign MEMWB_EN     = memwb_en;
    assign MEMWB_FLUSH  = memwb_flush;
    assign MEM_ERR      = mem_err_q;
    assign STATE        = state_q;
    assign STALL_CYCLES = stall_q;

endmodule
